// File: rtl/multisim_server_apb_pull.sv
// Server-side APB replay endpoint: buffers deserialised requests, replays each as
// one APB SETUP/ACCESS transfer, and holds the captured response for the transport.
module multisim_server_apb_pull #(
  parameter type apb_req_t      = logic [63:0],
  parameter type apb_resp_t     = logic [31:0],
  parameter int  REQ_FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [$bits(apb_req_t)-1:0]  i_req,
  output logic                   o_resp_valid,
  input  logic                   i_resp_ready,
  output logic [$bits(apb_resp_t)-1:0] o_resp,
  output logic [$bits(apb_req_t)-1:0]  o_apb_m_req,
  input  logic [$bits(apb_resp_t)-1:0] i_apb_m_resp,
  output logic                   o_apb_m_psel,
  output logic                   o_apb_m_penable,
  input  logic                   i_apb_m_pready,
  output logic                   o_busy,
  output logic [31:0]            o_txn_count
);

  localparam int AW = $clog2(REQ_FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int REQ_W  = $bits(apb_req_t);
  localparam int RESP_W = $bits(apb_resp_t);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [REQ_W-1:0]    r_mem [REQ_FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [REQ_W-1:0]    r_apb_req;
  logic [RESP_W-1:0]   r_resp;
  logic [31:0]         r_txn_count;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_resp_hs;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = i_req_valid && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_resp_hs = (r_state == S_RESP) && i_resp_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (i_apb_m_pready) w_state_nxt = S_RESP;
      S_RESP:   if (i_resp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_apb_m_psel    = 1'b0;
    o_apb_m_penable = 1'b0;
    o_resp_valid    = 1'b0;
    case (r_state)
      S_SETUP:  o_apb_m_psel = 1'b1;
      S_ACCESS: begin
        o_apb_m_psel    = 1'b1;
        o_apb_m_penable = 1'b1;
      end
      S_RESP:   o_resp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Request register only moves on a pop, so it stays stable through ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_apb_req   <= '0;
      r_resp      <= '0;
      r_txn_count <= '0;
    end else begin
      if (w_pop) r_apb_req <= r_mem[r_rd_ptr[AW-1:0]];
      if ((r_state == S_ACCESS) && i_apb_m_pready) r_resp <= i_apb_m_resp;
      if (w_resp_hs) r_txn_count <= r_txn_count + 32'd1;
    end
  end

  assign o_req_ready = !w_full;
  assign o_apb_m_req = r_apb_req;
  assign o_resp      = r_resp;
  assign o_txn_count = r_txn_count;
  assign o_busy      = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_multisim_server_apb_pull.sv
// Directed bench for multisim_server_apb_pull; the APB slave answers with the
// low request word XOR 0xA5A5_A5A5, so every expected response is a constant.
module tb_multisim_server_apb_pull;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [63:0] i_req;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp;
  logic [63:0] o_apb_m_req;
  logic [31:0] i_apb_m_resp;
  logic        o_apb_m_psel;
  logic        o_apb_m_penable;
  logic        i_apb_m_pready;
  logic        o_busy;
  logic [31:0] o_txn_count;

  int checks;
  int failures;

  multisim_server_apb_pull dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req           (i_req),
    .o_resp_valid    (o_resp_valid),
    .i_resp_ready    (i_resp_ready),
    .o_resp          (o_resp),
    .o_apb_m_req     (o_apb_m_req),
    .i_apb_m_resp    (i_apb_m_resp),
    .o_apb_m_psel    (o_apb_m_psel),
    .o_apb_m_penable (o_apb_m_penable),
    .i_apb_m_pready  (i_apb_m_pready),
    .o_busy          (o_busy),
    .o_txn_count     (o_txn_count)
  );

  // clock / slave model
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign i_apb_m_resp = o_apb_m_req[31:0] ^ 32'hA5A5_A5A5;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] data);
    i_req_valid = 1'b1;
    i_req       = data;
    step();
    i_req_valid = 1'b0;
  endtask

  // Waits (bounded) for a response, checks it, then lets the handshake happen.
  task automatic wait_resp(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!o_resp_valid && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, o_resp_valid, 1'b1);
    chk({tag, "_data"}, o_resp, exp);
    step();
  endtask

  initial begin
    int bad;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    i_req_valid = 1'b0;
    i_req = '0;
    i_resp_ready = 1'b0;
    i_apb_m_pready = 1'b0;
    repeat (3) step();

    chk("rst_req_ready", o_req_ready, 1'b1);
    chk("rst_psel", o_apb_m_psel, 1'b0);
    chk("rst_penable", o_apb_m_penable, 1'b0);
    chk("rst_resp_valid", o_resp_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_txn", o_txn_count, 32'd0);
    chk("rst_apb_req", o_apb_m_req, 64'd0);
    chk("rst_resp", o_resp, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: single write, zero wait states
    i_apb_m_pready = 1'b1;
    i_resp_ready = 1'b1;
    push(64'h0000_1000_DEAD_BEEF);
    chk("t1_busy", o_busy, 1'b1);
    chk("t1_psel_pop", o_apb_m_psel, 1'b0);
    step();
    chk("t1_setup_psel", o_apb_m_psel, 1'b1);
    chk("t1_setup_penable", o_apb_m_penable, 1'b0);
    chk("t1_setup_req", o_apb_m_req, 64'h0000_1000_DEAD_BEEF);
    step();
    chk("t1_access_psel", o_apb_m_psel, 1'b1);
    chk("t1_access_penable", o_apb_m_penable, 1'b1);
    step();
    chk("t1_resp_valid", o_resp_valid, 1'b1);
    chk("t1_resp", o_resp, 32'h7B08_1B4A);
    chk("t1_resp_psel", o_apb_m_psel, 1'b0);
    step();
    chk("t1_resp_valid_drop", o_resp_valid, 1'b0);
    chk("t1_txn", o_txn_count, 32'd1);
    chk("t1_idle_busy", o_busy, 1'b0);

    // 2: five wait states then ready
    i_apb_m_pready = 1'b0;
    push(64'h0000_1004_1234_5678);
    step();
    chk("t2_setup", {o_apb_m_psel, o_apb_m_penable}, 2'b10);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait_sel", {o_apb_m_psel, o_apb_m_penable}, 2'b11);
      chk("t2_wait_req", o_apb_m_req, 64'h0000_1004_1234_5678);
      step();
    end
    chk("t2_last_sel", {o_apb_m_psel, o_apb_m_penable}, 2'b11);
    i_apb_m_pready = 1'b1;
    step();
    chk("t2_resp_valid", o_resp_valid, 1'b1);
    chk("t2_resp", o_resp, 32'hB791_F3DD);
    step();
    chk("t2_resp_once", o_resp_valid, 1'b0);
    chk("t2_txn", o_txn_count, 32'd2);

    // 3: back-pressure with three requests
    i_resp_ready = 1'b0;
    chk("t3_ready_a", o_req_ready, 1'b1);
    push(64'h0000_2000_0000_0011);
    chk("t3_ready_b", o_req_ready, 1'b1);
    push(64'h0000_2000_0000_0022);
    chk("t3_ready_c", o_req_ready, 1'b1);
    push(64'h0000_2000_0000_0033);
    chk("t3_full", o_req_ready, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_valid", o_resp_valid, 1'b1);
      chk("t3_stall_resp", o_resp, 32'hA5A5_A5B4);
      chk("t3_stall_psel", o_apb_m_psel, 1'b0);
      step();
    end
    i_req_valid = 1'b1;
    i_req = 64'h0000_2000_0000_00FF;
    step();
    i_req_valid = 1'b0;
    i_resp_ready = 1'b1;
    wait_resp("t3_a", 32'hA5A5_A5B4);
    wait_resp("t3_b", 32'hA5A5_A587);
    wait_resp("t3_c", 32'hA5A5_A596);
    // refused push while full must not create a fourth transaction
    chk("t3_drained", o_busy, 1'b0);
    chk("t3_txn", o_txn_count, 32'd5);

    // 4: push and pop in the same IDLE cycle with one entry buffered
    i_resp_ready = 1'b0;
    push(64'h0000_3000_0000_0044);
    push(64'h0000_3000_0000_0055);
    bad = 0;
    while (!o_resp_valid && bad < 20) begin
      step();
      bad++;
    end
    chk("t4_d_resp", o_resp, 32'hA5A5_A5E1);
    i_resp_ready = 1'b1;
    step();
    chk("t4_idle_psel", o_apb_m_psel, 1'b0);
    chk("t4_idle_ready", o_req_ready, 1'b1);
    chk("t4_idle_busy", o_busy, 1'b1);
    push(64'h0000_3000_0000_0066);
    chk("t4_setup_req", o_apb_m_req, 64'h0000_3000_0000_0055);
    chk("t4_setup_sel", {o_apb_m_psel, o_apb_m_penable}, 2'b10);
    chk("t4_occ_one", o_req_ready, 1'b1);
    wait_resp("t4_e", 32'hA5A5_A5F0);
    wait_resp("t4_f", 32'hA5A5_A5C3);
    chk("t4_f_req", o_apb_m_req, 64'h0000_3000_0000_0066);
    chk("t4_empty", o_busy, 1'b0);
    chk("t4_txn", o_txn_count, 32'd8);

    // 5: async reset in the middle of ACCESS with one request queued
    i_apb_m_pready = 1'b0;
    push(64'h0000_4000_0000_0001);
    push(64'h0000_4000_0000_0002);
    step();
    chk("t5_access", {o_apb_m_psel, o_apb_m_penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_psel", o_apb_m_psel, 1'b0);
    chk("t5_penable", o_apb_m_penable, 1'b0);
    chk("t5_busy", o_busy, 1'b0);
    chk("t5_txn", o_txn_count, 32'd0);
    chk("t5_resp_valid", o_resp_valid, 1'b0);
    step();
    rst_n = 1'b1;
    i_apb_m_pready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_resp_valid || o_apb_m_psel) bad++;
    end
    chk("t5_no_replay", bad, 0);
    chk("t5_txn_after", o_txn_count, 32'd0);

    // 6: transaction counter wraps
    force dut.r_txn_count = 32'hFFFF_FFFF;
    step();
    release dut.r_txn_count;
    step();
    chk("t6_preload", o_txn_count, 32'hFFFF_FFFF);
    push(64'h0000_5000_0000_0077);
    wait_resp("t6", 32'hA5A5_A5D2);
    chk("t6_wrap", o_txn_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
